// File: rtl/pmu_counter_bank.sv
// -----------------------------------------------------------------------------
// pmu_counter_bank
//
// Register bank and responder for the PMU counter interface. Holds the event
// counters, the control register (count enable / clear-all) and the sticky
// overflow register. It answers four-phase enable/valid handshakes from the
// PMU AXI bridge. That bridge may run on an unrelated clock, so both request
// levels are brought in through 2-flop synchronizers.
//
// Address map (byte addresses; bits [2:0] ignored):
//   0x00        CTRL  bit0 count enable (R/W), bit1 clear-all (write-only, reads 0)
//   0x08        OVF   sticky per-counter overflow, write-1-to-clear
//   0x10 + 8*i  counter i (R/W)
//   other       reads 0, writes ignored but acknowledged
//
// Ports:
//   clk, rst                  bank clock, asynchronous active-high reset
//   events                    per-counter increment pulses
//   counter_read_enable       read request level (asynchronous)
//   counter_read_address      read byte address
//   counter_read_valid        read acknowledge level
//   counter_read_data         read result, held until the next read
//   counter_write_enable      write request level (asynchronous)
//   counter_write_address     write byte address
//   counter_write_data        write data
//   counter_write_valid       write acknowledge level
// -----------------------------------------------------------------------------
module pmu_counter_bank #(
  parameter int N_COUNTERS            = 16,
  parameter int COUNTER_ADDRESS_WIDTH = 16,
  parameter int COUNTER_DATA_WIDTH    = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_COUNTERS-1:0]            events,
  input  logic                             counter_read_enable,
  input  logic [COUNTER_ADDRESS_WIDTH-1:0] counter_read_address,
  output logic                             counter_read_valid,
  output logic [COUNTER_DATA_WIDTH-1:0]    counter_read_data,
  input  logic                             counter_write_enable,
  input  logic [COUNTER_ADDRESS_WIDTH-1:0] counter_write_address,
  input  logic [COUNTER_DATA_WIDTH-1:0]    counter_write_data,
  output logic                             counter_write_valid
);

  localparam int AW    = COUNTER_ADDRESS_WIDTH;
  localparam int DW    = COUNTER_DATA_WIDTH;
  localparam int IDX_W = AW - 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ACK = 2'd1,
    WR_ACK = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Request synchronizers
  // ---------------------------------------------------------------------------
  logic [1:0] rd_sync;
  logic [1:0] wr_sync;
  logic       rd_en_s;
  logic       wr_en_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sync <= '0;
      wr_sync <= '0;
    end else begin
      rd_sync <= {rd_sync[0], counter_read_enable};
      wr_sync <= {wr_sync[0], counter_write_enable};
    end
  end

  assign rd_en_s = rd_sync[1];
  assign wr_en_s = wr_sync[1];

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   do_write;
  logic   do_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // Writes take priority; a held read is picked up after WR_ACK.
        if (wr_en_s)      state_next = WR_ACK;
        else if (rd_en_s) state_next = RD_ACK;
      end
      WR_ACK:  if (!wr_en_s) state_next = IDLE;
      RD_ACK:  if (!rd_en_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Valids decode straight from the state register, so an asynchronous reset
  // drops them at once.
  always_comb begin
    do_write            = (state == IDLE) && wr_en_s;
    do_read             = (state == IDLE) && rd_en_s && !wr_en_s;
    counter_write_valid = (state == WR_ACK);
    counter_read_valid  = (state == RD_ACK);
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_ctrl;
  logic                  wr_ovf;
  logic                  clear_all;
  logic [N_COUNTERS-1:0] wr_hit;
  logic [N_COUNTERS-1:0] ovf_clr;
  logic                  unused_addr_bits;

  assign wr_idx = counter_write_address[AW-1:3];
  assign rd_idx = counter_read_address[AW-1:3];

  // Byte-lane bits carry no meaning in this register file.
  assign unused_addr_bits = ^{counter_read_address[2:0], counter_write_address[2:0]};

  assign wr_ctrl   = do_write && (wr_idx == IDX_W'(0));
  assign wr_ovf    = do_write && (wr_idx == IDX_W'(1));
  assign clear_all = wr_ctrl && counter_write_data[1];

  // OVF bits map onto write-data bits, so DW is expected to be >= N_COUNTERS.
  always_comb begin
    wr_hit  = '0;
    ovf_clr = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      wr_hit[i]  = do_write && (wr_idx == IDX_W'(i + 2));
      ovf_clr[i] = wr_ovf && counter_write_data[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, control and overflow
  // ---------------------------------------------------------------------------
  logic                  ctrl_en;
  logic [N_COUNTERS-1:0] ovf;
  logic [DW-1:0]         cnt [N_COUNTERS];
  logic [N_COUNTERS-1:0] inc;
  logic [N_COUNTERS-1:0] wrap;

  // A software write or clear-all in the same cycle drops the increment.
  always_comb begin
    inc  = '0;
    wrap = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      inc[i]  = ctrl_en && events[i] && !wr_hit[i] && !clear_all;
      wrap[i] = inc[i] && (&cnt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en <= counter_write_data[0];
    end
  end

  // A wrap is ORed in after the W1C mask, so a same-cycle wrap keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf <= '0;
    else if (clear_all) ovf <= '0;
    else                ovf <= (ovf & ~ovf_clr) | wrap;
  end

  // NOTE: the counter array is built from flops rather than a RAM, so it
  // takes the asynchronous reset like any other register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_COUNTERS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_COUNTERS; i++) begin
        if (clear_all)      cnt[i] <= '0;
        else if (wr_hit[i]) cnt[i] <= counter_write_data;
        else if (inc[i])    cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: snapshot of the pre-edge register value
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (rd_idx == IDX_W'(0)) rd_mux[0] = ctrl_en;
    if (rd_idx == IDX_W'(1)) rd_mux[N_COUNTERS-1:0] = ovf;
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (rd_idx == IDX_W'(i + 2)) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          counter_read_data <= '0;
    else if (do_read) counter_read_data <= rd_mux;
  end

endmodule

// File: tb/tb_pmu_counter_bank.sv
module tb_pmu_counter_bank;

  localparam int N  = 16;
  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  events = '0;
  logic          counter_read_enable = 1'b0;
  logic [AW-1:0] counter_read_address = '0;
  logic          counter_read_valid;
  logic [DW-1:0] counter_read_data;
  logic          counter_write_enable = 1'b0;
  logic [AW-1:0] counter_write_address = '0;
  logic [DW-1:0] counter_write_data = '0;
  logic          counter_write_valid;

  int checks = 0;
  int errors = 0;

  pmu_counter_bank #(
    .N_COUNTERS(N),
    .COUNTER_ADDRESS_WIDTH(AW),
    .COUNTER_DATA_WIDTH(DW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .events                (events),
    .counter_read_enable   (counter_read_enable),
    .counter_read_address  (counter_read_address),
    .counter_read_valid    (counter_read_valid),
    .counter_read_data     (counter_read_data),
    .counter_write_enable  (counter_write_enable),
    .counter_write_address (counter_write_address),
    .counter_write_data    (counter_write_data),
    .counter_write_valid   (counter_write_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [N-1:0]  pre_mask;  // events pulsed before the transaction
    int            pre_n;     // number of cycles pre_mask is held
    logic [N-1:0]  hold;      // events held from request until acknowledge
    logic [DW-1:0] exp;       // expected read data (reads only)
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [N-1:0] pre_mask, input int pre_n,
                     input logic [N-1:0] hold, input logic [DW-1:0] exp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.pre_mask = pre_mask; v.pre_n = pre_n; v.hold = hold; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full four-phase transaction, entered and left on a falling edge.
  // rise/fall count falling edges from enable change to valid change.
  task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [N-1:0] hold, output logic [DW-1:0] rdata,
                      output int rise, output int fall);
    if (wr) begin
      counter_write_address = addr;
      counter_write_data    = wdata;
      counter_write_enable  = 1'b1;
    end else begin
      counter_read_address = addr;
      counter_read_enable  = 1'b1;
    end
    events = hold;
    rise = 0;
    while (!(wr ? counter_write_valid : counter_read_valid) && rise < 20) begin
      @(negedge clk);
      rise++;
    end
    events = '0;
    rdata = counter_read_data;
    counter_write_enable = 1'b0;
    counter_read_enable  = 1'b0;
    fall = 0;
    while ((wr ? counter_write_valid : counter_read_valid) && fall < 20) begin
      @(negedge clk);
      fall++;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rdata;
    int rise, fall, n;

    // wr  addr     wdata                  pre_mask pre_n hold     exp
    add(0, 16'h10,  '0,                    '0,      0,    '0,      64'd0);   // reset read
    add(1, 16'h00,  64'd1,                 '0,      0,    '0,      '0);      // enable counting
    add(0, 16'h00,  '0,                    '0,      0,    '0,      64'd1);
    add(0, 16'h20,  '0,                    16'h0004,5,    '0,      64'd5);   // 5 events on ctr 2
    add(0, 16'h18,  '0,                    '0,      0,    '0,      64'd0);
    add(1, 16'h10,  64'hFFFF_FFFF_FFFF_FFFE,'0,     0,    '0,      '0);
    add(0, 16'h10,  '0,                    16'h0001,2,    '0,      64'd0);   // wraps
    add(0, 16'h08,  '0,                    '0,      0,    '0,      64'd1);
    add(1, 16'h08,  64'd1,                 '0,      0,    '0,      '0);      // W1C
    add(0, 16'h08,  '0,                    '0,      0,    '0,      64'd0);
    add(1, 16'h10,  64'hFFFF_FFFF_FFFF_FFFD,'0,     0,    '0,      '0);
    add(1, 16'h08,  64'd1,                 '0,      0,    16'h0001,'0);      // wrap on W1C edge
    add(0, 16'h08,  '0,                    '0,      0,    '0,      64'd1);
    add(0, 16'h10,  '0,                    '0,      0,    '0,      64'd0);
    add(1, 16'h10,  64'd100,               '0,      0,    16'h0001,'0);      // write beats event
    add(0, 16'h10,  '0,                    '0,      0,    '0,      64'd100);
    add(0, 16'h20,  '0,                    '0,      0,    '0,      64'd5);
    add(0, 16'h03,  '0,                    '0,      0,    '0,      64'd1);   // low bits ignored
    add(1, 16'h400, 64'hFFFF,              '0,      0,    '0,      '0);      // unmapped write
    add(0, 16'h400, '0,                    '0,      0,    '0,      64'd0);
    add(0, 16'h88,  '0,                    '0,      0,    '0,      64'd0);   // last counter
    add(0, 16'h90,  '0,                    '0,      0,    '0,      64'd0);   // past last counter
    add(1, 16'h00,  64'd3,                 '0,      0,    16'hFFFF,'0);      // clear-all under events
    add(0, 16'h10,  '0,                    '0,      0,    '0,      64'd0);
    add(0, 16'h20,  '0,                    '0,      0,    '0,      64'd0);
    add(0, 16'h08,  '0,                    '0,      0,    '0,      64'd0);
    add(0, 16'h00,  '0,                    '0,      0,    '0,      64'd1);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rd_valid", {63'd0, counter_read_valid}, 64'd0);
    check("reset wr_valid", {63'd0, counter_write_valid}, 64'd0);
    check("reset rd_data", counter_read_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].pre_n > 0) begin
        events = tbl[i].pre_mask;
        repeat (tbl[i].pre_n) @(negedge clk);
        events = '0;
        @(negedge clk);
      end
      xact(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rdata, rise, fall);
      check($sformatf("vec%0d rise", i), DW'(rise), 64'd3);
      check($sformatf("vec%0d fall", i), DW'(fall), 64'd3);
      if (!tbl[i].wr) check($sformatf("vec%0d data", i), rdata, tbl[i].exp);
    end

    // Simultaneous read and write of counter 1: write first, read sees 7.
    counter_write_address = 16'h18;
    counter_write_data    = 64'd7;
    counter_read_address  = 16'h18;
    counter_write_enable  = 1'b1;
    counter_read_enable   = 1'b1;
    n = 0;
    while (!counter_write_valid && n < 20) begin @(negedge clk); n++; end
    check("both wr rise", DW'(n), 64'd3);
    check("both rd held off", {63'd0, counter_read_valid}, 64'd0);
    counter_write_enable = 1'b0;
    // wr valid low at F2 (3rd edge), read served on the next edge.
    n = 0;
    while (!counter_read_valid && n < 20) begin @(negedge clk); n++; end
    check("both rd rise", DW'(n), 64'd4);
    check("both wr dropped", {63'd0, counter_write_valid}, 64'd0);
    check("both rd data", counter_read_data, 64'd7);
    counter_read_enable = 1'b0;
    n = 0;
    while (counter_read_valid && n < 20) begin @(negedge clk); n++; end
    check("both rd fall", DW'(n), 64'd3);
    @(negedge clk);

    // Reset in the middle of a read acknowledge.
    counter_read_address = 16'h18;
    counter_read_enable  = 1'b1;
    n = 0;
    while (!counter_read_valid && n < 20) begin @(negedge clk); n++; end
    check("rst seq rise", DW'(n), 64'd3);
    check("rst seq data", counter_read_data, 64'd7);
    rst = 1'b1;
    #1;
    check("rst drops valid", {63'd0, counter_read_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!counter_read_valid && n < 20) begin @(negedge clk); n++; end
    check("post rst rise", DW'(n), 64'd3);
    check("post rst data", counter_read_data, 64'd0);
    counter_read_enable = 1'b0;
    n = 0;
    while (counter_read_valid && n < 20) begin @(negedge clk); n++; end
    check("post rst fall", DW'(n), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
